m_wblatregs: RTL and testbench
==============================

M_WBLATREGS -- requirements
Module: m_wblatregs

Interface
REQ-001 Parameter NREGS, default 4, number of 32-bit data registers (1..15).
REQ-002 Parameter LATW, default 6, width of each latency field in cycles (1..8).
REQ-003 Parameter RSTWLAT, default 0, reset value of the write-latency field.
REQ-004 Parameter RSTRLAT, default 0, reset value of the read-latency field.
REQ-005 CLK_I  in  1  single clock; all state changes on rising edge.
REQ-006 RST_I  in  1  reset, synchronous, active-high.
REQ-007 STB_I  in  1  wishbone strobe; the decoder outside the block already qualifies it with address.
REQ-008 WE_I  in  1  1 = write, 0 = read.
REQ-009 SEL_I  in  4  byte lane enables for writes; SEL_I[n] covers DAT_I[8n+7:8n].
REQ-010 ADR_I  in  4  word index: 0 = latency control register (LCR); 1..NREGS = data registers; above NREGS = unmapped.
REQ-011 DAT_I  in  32  write data.
REQ-012 ACK_O  out  1  registered acknowledge, one-cycle pulse.
REQ-013 DAT_O  out  32  read data; valid only while ACK_O=1, otherwise 0 so it can be OR-combined on a bus.
REQ-014 busy  out  1  high while the state is WAIT or ACK.
REQ-015 lcr  out  32  current LCR value.

Function
REQ-016 LCR layout: write latency in bits [LATW-1:0]; read latency in bits [8+LATW-1:8]; all other bits read 0 and ignore writes.
REQ-017 The FSM has three states: IDLE, WAIT and ACK.
REQ-018 In IDLE, STB_I=1 sampled at edge k SHALL load the following into the counter CNT and go to WAIT:
- the write latency when WE_I=1;
- the read latency when WE_I=0.
REQ-019 In WAIT with STB_I=1 and CNT!=0: decrement CNT and stay in WAIT.
REQ-020 In WAIT with STB_I=1 and CNT=0: go to ACK, so that ACK_O is high in the cycle after edge k+L+1, where L is the loaded latency.
REQ-021 Latency arithmetic: L=0 gives ACK_O high in the second cycle after STB_I is first sampled; the maximum is L=2^LATW-1; CNT is LATW bits wide and never wraps.
REQ-022 ACK lasts exactly one cycle; the next state is always IDLE, whatever STB_I is, so back-to-back accesses are separated by at least one IDLE cycle.
REQ-023 Abort: STB_I=0 sampled in WAIT returns the FSM to IDLE; no ACK is issued and no register is modified.
REQ-024 Write commit happens on the WAIT->ACK edge:
- each selected byte lane of the addressed register is updated;
- unselected lanes keep their value;
- SEL_I=0 completes the access but changes nothing.
REQ-025 Read capture: DAT_O is loaded on the WAIT->ACK edge with the addressed register value, and the value is held for the ACK cycle.
REQ-026 WE_I, ADR_I, SEL_I and DAT_I are sampled on the commit edge, not on the start edge.
REQ-027 Unmapped index: the access is acknowledged with normal latency; a read returns 0 and a write is ignored.
REQ-028 An LCR write uses the latency in force when it started; the new value applies from the next access.
REQ-029 A write to a data register is visible to a read in the very next access, with no forwarding hazard.

Reset
REQ-030 RST_I=1 at an edge forces the following, overriding any access in flight; the aborted access is not committed and not acknowledged:
- state IDLE, CNT=0;
- ACK_O=0, DAT_O=0, busy=0;
- LCR write field = RSTWLAT, LCR read field = RSTRLAT;
- all data registers = 0.
REQ-031 The first edge with RST_I=0 may sample STB_I and start an access.

Verification
REQ-032 Reset defaults: after reset, a read of index 1 -> ACK_O in the 2nd cycle with DAT_O=0; a read of index 0 -> lcr and DAT_O = RSTRLAT<<8 | RSTWLAT.
REQ-033 Write LCR=0x0503 (write latency 3, read latency 5), then write 0xDEADBEEF to index 2 with SEL=1111 -> ACK_O 5 cycles after STB_I; read index 2 -> ACK_O 7 cycles after STB_I with DAT_O=0xDEADBEEF.
REQ-034 Byte lanes: write 0x11223344 to index 1 with SEL=1111, then 0xAABBCCDD with SEL=0101 -> read returns 0x11BB33DD.
REQ-035 Abort: read latency 10, drop STB_I after 4 cycles -> no ACK_O, busy=0 the next cycle; then a write with STB_I held -> normal ACK_O.
REQ-036 Reset mid-write: RST_I pulsed in WAIT -> no ACK_O, the target register reads 0 and lcr returns to its reset value.
REQ-037 Unmapped and boundary: write to index NREGS+1 -> ACK_O, no register changes, and a read of it returns 0; latency 2^LATW-1 -> ACK_O exactly 2^LATW+1 cycles after STB_I.

Source files
------------

// File: rtl/m_wblatregs_if.sv
// Wishbone-style slave bus bundle for the latency-programmable register block.
interface m_wblatregs_if;
  logic        STB_I;
  logic        WE_I;
  logic [3:0]  SEL_I;
  logic [3:0]  ADR_I;
  logic [31:0] DAT_I;
  logic        ACK_O;
  logic [31:0] DAT_O;

  modport master (
    output STB_I, WE_I, SEL_I, ADR_I, DAT_I,
    input  ACK_O, DAT_O
  );

  modport slave (
    input  STB_I, WE_I, SEL_I, ADR_I, DAT_I,
    output ACK_O, DAT_O
  );
endinterface

// File: rtl/m_wblatregs.sv
// Register block with a programmable access latency: index 0 holds the
// latency control register (write/read latency fields), indices 1..NREGS
// are byte-writable 32-bit data registers. Every access waits its latency
// in WAIT, commits or captures on the WAIT->ACK edge, then acks for a cycle.
module m_wblatregs #(
  parameter int NREGS   = 4,
  parameter int LATW    = 6,
  parameter int RSTWLAT = 0,
  parameter int RSTRLAT = 0
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  m_wblatregs_if.slave  wb,
  output logic          busy,
  output logic [31:0]   lcr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LATW-1:0]   cnt_q, cnt_d;
  logic [LATW-1:0]   wlat_q, wlat_d;
  logic [LATW-1:0]   rlat_q, rlat_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [31:0]       regs_q [1:NREGS];
  logic [31:0]       regs_d [1:NREGS];
  logic [31:0]       rd_val;
  logic [31:0]       lcr_v;

  // Assemble the LCR view; unused bits are hard zero.
  always_comb begin
    lcr_v              = '0;
    lcr_v[LATW-1:0]    = wlat_q;
    lcr_v[8 +: LATW]   = rlat_q;
  end

  // Read mux over LCR and data registers; unmapped indices read zero.
  always_comb begin
    rd_val = '0;
    if (wb.ADR_I == 4'd0) begin
      rd_val = lcr_v;
    end else begin
      for (int i = 1; i <= NREGS; i++) begin
        if (wb.ADR_I == 4'(i)) rd_val = regs_q[i];
      end
    end
  end

  // Next-state logic: latency countdown, abort on strobe loss, commit/capture at WAIT->ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wlat_d  = wlat_q;
    rlat_d  = rlat_q;
    ack_d   = 1'b0;
    dat_d   = '0;
    regs_d  = regs_q;
    case (state_q)
      S_IDLE: begin
        if (wb.STB_I) begin
          cnt_d   = wb.WE_I ? wlat_q : rlat_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb.STB_I) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - LATW'(1);
        end else begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          if (!wb.WE_I) begin
            dat_d = rd_val;
          end else if (wb.ADR_I == 4'd0) begin
            // Each latency field sits in its own byte lane.
            if (wb.SEL_I[0]) wlat_d = wb.DAT_I[LATW-1:0];
            if (wb.SEL_I[1]) rlat_d = wb.DAT_I[8 +: LATW];
          end else begin
            for (int i = 1; i <= NREGS; i++) begin
              if (wb.ADR_I == 4'(i)) begin
                for (int b = 0; b < 4; b++) begin
                  if (wb.SEL_I[b]) regs_d[i][8*b +: 8] = wb.DAT_I[8*b +: 8];
                end
              end
            end
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter, ack/data and register-file flops; reset overrides any access in flight.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wlat_q  <= LATW'(RSTWLAT);
      rlat_q  <= LATW'(RSTRLAT);
      ack_q   <= 1'b0;
      dat_q   <= '0;
      for (int i = 1; i <= NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wlat_q  <= wlat_d;
      rlat_q  <= rlat_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      for (int i = 1; i <= NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign wb.ACK_O = ack_q;
  assign wb.DAT_O = dat_q;
  assign busy     = (state_q == S_WAIT) || (state_q == S_ACK);
  assign lcr      = lcr_v;

endmodule

// File: tb/tb_m_wblatregs.sv
// Directed bench for m_wblatregs: the driver pushes expected responses into a
// scoreboard queue, an independent monitor pops and checks on every ACK.
module tb_m_wblatregs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [31:0] lcr;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] dat;
    int          lat;
    int          start;
  } exp_t;

  exp_t sbq [$];

  m_wblatregs_if bus ();

  m_wblatregs #(.NREGS(4), .LATW(6), .RSTWLAT(0), .RSTRLAT(0)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .wb    (bus.slave),
    .busy  (busy),
    .lcr   (lcr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ACK must match the oldest expected response (latency and read data).
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.ACK_O) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: ACK_O=1 with no access outstanding at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checks++;
          if (cyc - e.start != e.lat) begin
            errors++;
            $display("FAIL ack_latency: got %0d cycles, expected %0d", cyc - e.start, e.lat);
          end
          if (!e.we) begin
            checks++;
            if (bus.DAT_O !== e.dat) begin
              errors++;
              $display("FAIL read_data: got %08h, expected %08h", bus.DAT_O, e.dat);
            end
          end
        end
      end else begin
        checks++;
        if (bus.DAT_O !== 32'h0) begin
          errors++;
          $display("FAIL dat_idle_zero: DAT_O=%08h without ACK, expected 00000000", bus.DAT_O);
        end
      end
    end
  end

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, got, exp);
    end
  endtask

  task automatic access(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input logic [31:0] exp_dat, input int exp_lat);
    exp_t e;
    bit   done;
    @(negedge clk);
    bus.STB_I = 1'b1;
    bus.WE_I  = we;
    bus.ADR_I = adr;
    bus.SEL_I = sel;
    bus.DAT_I = dat;
    e.we = we; e.dat = exp_dat; e.lat = exp_lat; e.start = cyc;
    sbq.push_back(e);
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (n == 0) chk32("busy_in_wait", {31'b0, busy}, 32'h1);
      if (bus.ACK_O) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL ack_timeout: no ACK_O for adr %0d within 300 cycles", adr);
      void'(sbq.pop_front());
    end
    bus.STB_I = 1'b0;
  endtask

  initial begin
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    bus.ADR_I = 4'd0;
    bus.SEL_I = 4'd0;
    bus.DAT_I = 32'h0;

    repeat (3) @(negedge clk);
    chk32("rst_ack",  {31'b0, bus.ACK_O}, 32'h0);
    chk32("rst_dat",  bus.DAT_O, 32'h0);
    chk32("rst_busy", {31'b0, busy}, 32'h0);
    chk32("rst_lcr",  lcr, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset defaults: zero latency, everything reads zero.
    access(1'b0, 4'd1, 4'h0, 32'h0, 32'h0, 2);
    access(1'b0, 4'd0, 4'h0, 32'h0, 32'h0, 2);

    // Program w=3, r=5 and exercise a full write/read.
    access(1'b1, 4'd0, 4'hF, 32'h0000_0503, 32'h0, 2);
    chk32("lcr_0503", lcr, 32'h0000_0503);
    access(1'b1, 4'd2, 4'hF, 32'hDEAD_BEEF, 32'h0, 5);
    access(1'b0, 4'd2, 4'h0, 32'h0, 32'hDEAD_BEEF, 7);

    // Byte lanes.
    access(1'b1, 4'd1, 4'hF, 32'h1122_3344, 32'h0, 5);
    access(1'b1, 4'd1, 4'h5, 32'hAABB_CCDD, 32'h0, 5);
    access(1'b0, 4'd1, 4'h0, 32'h0, 32'h11BB_33DD, 7);

    // Read latency 10, then abort a read after 4 cycles.
    access(1'b1, 4'd0, 4'hF, 32'h0000_0A03, 32'h0, 5);
    chk32("lcr_0a03", lcr, 32'h0000_0A03);
    @(negedge clk);
    bus.STB_I = 1'b1; bus.WE_I = 1'b0; bus.ADR_I = 4'd1;
    repeat (4) @(negedge clk);
    chk32("abort_busy_before", {31'b0, busy}, 32'h1);
    bus.STB_I = 1'b0;
    @(negedge clk);
    chk32("abort_busy_after", {31'b0, busy}, 32'h0);
    repeat (12) @(negedge clk);
    access(1'b1, 4'd4, 4'hF, 32'h1234_5678, 32'h0, 5);
    access(1'b0, 4'd4, 4'h0, 32'h0, 32'h1234_5678, 12);

    // Unmapped index: acked, write ignored, reads zero; others untouched.
    access(1'b1, 4'd5, 4'hF, 32'hCAFE_F00D, 32'h0, 5);
    access(1'b0, 4'd5, 4'h0, 32'h0, 32'h0, 12);
    access(1'b0, 4'd15, 4'h0, 32'h0, 32'h0, 12);
    access(1'b0, 4'd1, 4'h0, 32'h0, 32'h11BB_33DD, 12);
    access(1'b0, 4'd2, 4'h0, 32'h0, 32'hDEAD_BEEF, 12);

    // Maximum latency; reserved LCR bits read zero; new LCR applies to the next access.
    access(1'b1, 4'd0, 4'hF, 32'hFFFF_FFFF, 32'h0, 5);
    chk32("lcr_max", lcr, 32'h0000_3F3F);
    access(1'b1, 4'd3, 4'hF, 32'h55AA_55AA, 32'h0, 65);
    access(1'b0, 4'd3, 4'h0, 32'h0, 32'h55AA_55AA, 65);

    // Reset in the middle of a write.
    @(negedge clk);
    bus.STB_I = 1'b1; bus.WE_I = 1'b1; bus.ADR_I = 4'd3;
    bus.SEL_I = 4'hF; bus.DAT_I = 32'h0BAD_0BAD;
    repeat (5) @(negedge clk);
    chk32("midrst_busy_before", {31'b0, busy}, 32'h1);
    rst = 1'b1; bus.STB_I = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk32("midrst_busy_after", {31'b0, busy}, 32'h0);
    chk32("midrst_lcr", lcr, 32'h0);
    repeat (4) @(negedge clk);
    access(1'b0, 4'd3, 4'h0, 32'h0, 32'h0, 2);
    access(1'b0, 4'd2, 4'h0, 32'h0, 32'h0, 2);

    // SEL=0 completes but changes nothing.
    access(1'b1, 4'd1, 4'h0, 32'hFFFF_FFFF, 32'h0, 2);
    access(1'b0, 4'd1, 4'h0, 32'h0, 32'h0, 2);

    repeat (5) @(negedge clk);
    chk32("scoreboard_empty", sbq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
